// File: rtl/sort_pkg.sv
// Shared definitions for the sort block, its frame loader and their benches:
// default geometry, loader state encoding, pad value and slot placement.
package sort_pkg;

  localparam int SORT_NUM_VALS  = 9;
  localparam int SORT_SIZE      = 16;
  localparam int SORT_PAD_MAX_W = 256;

  // Padding sorts to the maximum end, so unused slots never displace real samples.
  localparam logic [SORT_PAD_MAX_W-1:0] SORT_PAD = '1;

  typedef enum logic {
    LD_FILL = 1'b0,
    LD_FULL = 1'b1
  } ld_state_e;

  // Slot 0 sits at the MSB end, matching the in1..inN concatenation of sort.
  function automatic int slot_lsb(input int k, input int num_vals, input int size);
    return (num_vals - 1 - k) * size;
  endfunction

endpackage

// File: rtl/sort_slot_reg.sv
// One sample slot of the loader fill buffer: loads a sample, or the pad value
// when a frame closes early, and exposes both its next and current value.
module sort_slot_reg
  import sort_pkg::*;
#(
  parameter int SIZE = SORT_SIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic            pad_ld,
  input  logic [SIZE-1:0] wr_data,
  output logic [SIZE-1:0] slot_d,
  output logic [SIZE-1:0] slot_q
);

  always_comb begin
    slot_d = slot_q;
    if (wr_en) begin
      slot_d = wr_data;
    end else if (pad_ld) begin
      slot_d = SORT_PAD[SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/sort_frame_loader.sv
// Double-buffered loader packing NUM_VALS serial samples into one frame for sort.
// Define SORT_LOADER_PAD_EN to let s_last close a short, all-ones padded frame.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int NUM_VALS = SORT_NUM_VALS,
  parameter int SIZE     = SORT_SIZE
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SIZE-1:0]               s_data,
  input  logic                          s_last,
  output logic [NUM_VALS*SIZE-1:0]      frame,
  output logic [$clog2(NUM_VALS+1)-1:0] frame_len,
  output logic                          frame_valid,
  input  logic                          frame_ready
);

  localparam int IW = $clog2(NUM_VALS);
  localparam int LW = $clog2(NUM_VALS + 1);
  localparam int FW = NUM_VALS * SIZE;

  ld_state_e     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [LW-1:0] fill_len_q, fill_len_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [LW-1:0] frame_len_q, frame_len_d;
  logic          frame_valid_q, frame_valid_d;

  logic [FW-1:0]       fill_next, fill_held;
  logic [NUM_VALS-1:0] wr_sel, pad_sel;
  logic                accept, close_early, close_beat, out_free;
  logic [LW-1:0]       beat_len;

`ifdef SORT_LOADER_PAD_EN
  localparam bit PAD_EN = 1'b1;
  assign close_early = s_last;
`else
  localparam bit PAD_EN = 1'b0;
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign close_early   = 1'b0;
`endif

  // Ready depends only on registered state (and reset), never on frame_ready.
  assign s_ready    = rst_n && (state_q == LD_FILL);
  assign accept     = s_valid && s_ready;
  assign close_beat = accept && ((idx_q == IW'(NUM_VALS - 1)) || close_early);
  assign out_free   = !frame_valid_q || frame_ready;
  assign beat_len   = LW'(idx_q) + LW'(1);

  always_comb begin
    wr_sel  = '0;
    pad_sel = '0;
    for (int j = 0; j < NUM_VALS; j++) begin
      wr_sel[j]  = accept && (int'(idx_q) == j);
      pad_sel[j] = PAD_EN && close_beat && (int'(idx_q) < j);
    end
  end

  for (genvar k = 0; k < NUM_VALS; k++) begin : g_slot
    logic [SIZE-1:0] slot_d, slot_q;

    sort_slot_reg #(.SIZE(SIZE)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_sel[k]),
      .pad_ld  (pad_sel[k]),
      .wr_data (s_data),
      .slot_d  (slot_d),
      .slot_q  (slot_q)
    );

    assign fill_next[slot_lsb(k, NUM_VALS, SIZE) +: SIZE] = slot_d;
    assign fill_held[slot_lsb(k, NUM_VALS, SIZE) +: SIZE] = slot_q;
  end

  // A closing beat copies the buffer including itself; a stalled frame copies as held.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fill_len_d    = fill_len_q;
    frame_d       = frame_q;
    frame_len_d   = frame_len_q;
    frame_valid_d = frame_valid_q && !frame_ready;
    case (state_q)
      LD_FILL: begin
        if (accept) begin
          if (close_beat) begin
            idx_d      = '0;
            fill_len_d = beat_len;
            if (out_free) begin
              frame_d       = fill_next;
              frame_len_d   = beat_len;
              frame_valid_d = 1'b1;
            end else begin
              state_d = LD_FULL;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      LD_FULL: begin
        if (frame_ready) begin
          frame_d       = fill_held;
          frame_len_d   = fill_len_q;
          frame_valid_d = 1'b1;
          idx_d         = '0;
          state_d       = LD_FILL;
        end
      end
      default: state_d = LD_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LD_FILL;
      idx_q         <= '0;
      fill_len_q    <= '0;
      frame_q       <= '0;
      frame_len_q   <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fill_len_q    <= fill_len_d;
      frame_q       <= frame_d;
      frame_len_q   <= frame_len_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  assign frame       = frame_q;
  assign frame_len   = frame_len_q;
  assign frame_valid = frame_valid_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: directed table, corner sequences
// and random traffic against a queue-based frame model.
module tb_sort_frame_loader;

  localparam int N  = 9;
  localparam int S  = 16;
  localparam int LW = $clog2(N + 1);
  localparam int FW = N * S;

`ifdef SORT_LOADER_PAD_EN
  localparam bit PAD_MODE = 1'b1;
`else
  localparam bit PAD_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          frame_ready = 1'b0;
  logic [S-1:0]  s_data = '0;
  logic          s_ready;
  logic          frame_valid;
  logic [FW-1:0] frame;
  logic [LW-1:0] frame_len;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [FW-1:0] data;
    int            len;
  } exp_frame_t;

  typedef struct {
    logic [S-1:0] data;
    logic         fready;
    logic         exp_fvalid;
    logic         exp_sready;
    logic [S-1:0] exp_slot0;
  } vec_t;

  exp_frame_t    exp_q[$];
  logic [S-1:0]  cur_q[$];
  logic          hold_prev = 1'b0;
  logic [FW-1:0] prev_frame;
  logic [LW-1:0] prev_len;

  sort_frame_loader #(.NUM_VALS(N), .SIZE(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .frame       (frame),
    .frame_len   (frame_len),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                             input logic [FW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [S-1:0] getSlot(input logic [FW-1:0] f, input int k);
    return f[(N-k)*S-1 -: S];
  endfunction

  task automatic applyStimulus(input logic v, input logic [S-1:0] d, input logic l,
                               input logic fr);
    s_valid     = v;
    s_data      = d;
    s_last      = l;
    frame_ready = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic sendSample(input logic [S-1:0] d, input logic l);
    logic acc;
    int   waited;
    acc     = 1'b0;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 50);
    if (!acc) checkOutput("accept_timeout", acc, 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic doReset();
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("rst_frame", frame, 0);
    checkOutput("rst_frame_len", frame_len, 0);
    checkOutput("rst_frame_valid", frame_valid, 0);
    checkOutput("rst_s_ready", s_ready, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_release_s_ready", s_ready, 1);
    @(posedge clk);
    #1;
  endtask

  // Reference model: frames are the accepted samples grouped by count or s_last.
  initial begin
    exp_frame_t ef;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        cur_q.delete();
        hold_prev = 1'b0;
      end else begin
        checkOutput("mdl_s_ready", s_ready, exp_q.size() < 2);
        checkOutput("mdl_frame_valid", frame_valid, exp_q.size() > 0);
        if (hold_prev) begin
          checkOutput("hold_frame", frame, prev_frame);
          checkOutput("hold_len", frame_len, prev_len);
        end
        hold_prev  = frame_valid && !frame_ready;
        prev_frame = frame;
        prev_len   = frame_len;
        if (frame_valid && frame_ready && exp_q.size() > 0) begin
          ef = exp_q.pop_front();
          checkOutput("mdl_frame_data", frame, ef.data);
          checkOutput("mdl_frame_len", frame_len, ef.len);
        end
        if (s_valid && s_ready) begin
          cur_q.push_back(s_data);
          if (cur_q.size() == N || (PAD_MODE && s_last)) begin
            ef.data = '1;
            for (int k = 0; k < cur_q.size(); k++) ef.data[(N-k)*S-1 -: S] = cur_q[k];
            ef.len = cur_q.size();
            exp_q.push_back(ef);
            cur_q.delete();
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[18];
    for (int i = 0; i < 18; i++) begin
      vecs[i].data       = S'(i + 1);
      vecs[i].fready     = 1'b1;
      vecs[i].exp_fvalid = (i == 8) || (i == 17);
      vecs[i].exp_sready = 1'b1;
      vecs[i].exp_slot0  = (i < 9) ? S'(1) : S'(10);
    end

    #1;
    doReset();

    $display("[TB] streaming 1..18");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, vecs[i].data, 1'b0, vecs[i].fready);
      checkOutput("tbl_frame_valid", frame_valid, vecs[i].exp_fvalid);
      checkOutput("tbl_s_ready", s_ready, vecs[i].exp_sready);
      if (vecs[i].exp_fvalid) begin
        checkOutput("tbl_slot0", getSlot(frame, 0), vecs[i].exp_slot0);
        checkOutput("tbl_frame_len", frame_len, N);
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("stream_drained", frame_valid, 0);

    $display("[TB] backpressure");
    frame_ready = 1'b0;
    for (int i = 0; i < 18; i++) sendSample(S'(100 + i), 1'b0);
    checkOutput("bp_s_ready_low", s_ready, 0);
    checkOutput("bp_slot0", getSlot(frame, 0), 100);
    s_valid = 1'b1;
    s_data  = S'(118);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("bp_still_low", s_ready, 0);
    checkOutput("bp_slot8", getSlot(frame, 8), 108);
    frame_ready = 1'b1;
    for (int i = 18; i < 27; i++) sendSample(S'(100 + i), 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("bp_drained", frame_valid, 0);

    $display("[TB] s_last handling");
    frame_ready = 1'b0;
    sendSample(S'(5), 1'b0);
    sendSample(S'(3), 1'b0);
    sendSample(S'(7), 1'b1);
`ifdef SORT_LOADER_PAD_EN
    checkOutput("pad_valid", frame_valid, 1);
    checkOutput("pad_len", frame_len, 3);
    checkOutput("pad_slot2", getSlot(frame, 2), 7);
    checkOutput("pad_slot3", getSlot(frame, 3), 16'hFFFF);
    checkOutput("pad_slot8", getSlot(frame, 8), 16'hFFFF);
`else
    checkOutput("nopad_open", frame_valid, 0);
    for (int i = 1; i <= 6; i++) sendSample(S'(i), 1'b0);
    checkOutput("nopad_valid", frame_valid, 1);
    checkOutput("nopad_len", frame_len, N);
    checkOutput("nopad_slot2", getSlot(frame, 2), 7);
    checkOutput("nopad_slot3", getSlot(frame, 3), 1);
    checkOutput("nopad_slot8", getSlot(frame, 8), 6);
`endif
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] reset mid-frame");
    frame_ready = 1'b0;
    for (int i = 0; i < 9; i++) sendSample(S'(200 + i), 1'b0);
    for (int i = 0; i < 4; i++) sendSample(S'(220 + i), 1'b0);
    checkOutput("pre_rst_valid", frame_valid, 1);
    doReset();
    frame_ready = 1'b0;
    for (int i = 0; i < 9; i++) sendSample(S'(300 + i), 1'b0);
    checkOutput("post_rst_valid", frame_valid, 1);
    checkOutput("post_rst_slot0", getSlot(frame, 0), 300);
    checkOutput("post_rst_slot3", getSlot(frame, 3), 303);
    checkOutput("post_rst_slot8", getSlot(frame, 8), 308);

    $display("[TB] drain and copy together");
    for (int i = 0; i < 8; i++) sendSample(S'(400 + i), 1'b0);
    checkOutput("dc_old_slot0", getSlot(frame, 0), 300);
    frame_ready = 1'b1;
    sendSample(S'(408), 1'b0);
    checkOutput("dc_valid", frame_valid, 1);
    checkOutput("dc_slot0", getSlot(frame, 0), 400);
    checkOutput("dc_slot8", getSlot(frame, 8), 408);
    checkOutput("dc_len", frame_len, N);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, S'($urandom), $urandom_range(0, 7) == 0,
                    1'($urandom_range(0, 1)));
    end
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("final_model_empty", exp_q.size(), 0);
    checkOutput("final_valid", frame_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
